// File: rtl/event_blinker_pkg.sv
// Shared state encoding and default timing for LED/beeper blink drivers.
package event_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } blink_state_e;

  localparam int DEF_ON_CYC   = 32;
  localparam int DEF_OFF_CYC  = 16;
  localparam int DEF_MAX_PEND = 7;
  localparam int DEF_CNT_W    = 6;
  localparam int DEF_PEND_W   = 3;

  function automatic logic [1:0] sat_step(
    input logic inc,
    input logic dec
  );
    return {inc & ~dec, dec & ~inc};
  endfunction

endpackage

// File: rtl/event_blinker_sat_counter.sv
// Up/down saturating counter; simultaneous inc and dec leave it unchanged.
module event_blinker_sat_counter
  import event_blinker_pkg::*;
#(
  parameter int W   = DEF_PEND_W,
  parameter int MAX = DEF_MAX_PEND
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAXV = W'(MAX);

  logic [1:0] dir;

  assign dir = sat_step(inc, dec);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (dir[1] && count != MAXV) begin
      count <= count + 1'b1;
    end else if (dir[0] && count != '0) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/event_blinker.sv
// Turns single-cycle event flags into LED blinks with a pending queue.
// Optional EVBLINK_OVF_EN adds a sticky ovf output for dropped events.
module event_blinker
  import event_blinker_pkg::*;
#(
  parameter int ON_CYC   = DEF_ON_CYC,
  parameter int OFF_CYC  = DEF_OFF_CYC,
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PEND_W   = DEF_PEND_W
) (
  input  logic              clk_d,
  input  logic              rst_n,
  input  logic              ev_flag,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend
`ifdef EVBLINK_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(ON_CYC - 1);
  localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(OFF_CYC - 1);

  blink_state_e     state, state_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic             t_zero;
  logic             direct;
  logic             inc, dec;

  assign t_zero = (timer == '0);

  // An event is consumed directly only when nothing is queued ahead of it.
  assign direct = (state == IDLE) ||
                  (state == OFF && t_zero && pend == '0);
  assign inc    = ev_flag && !direct;
  assign dec    = (state == OFF) && t_zero && (pend != '0);

  always_comb begin
    state_n = state;
    timer_n = timer;
    unique case (state)
      IDLE: begin
        if (ev_flag) begin
          state_n = ON;
          timer_n = ON_LD;
        end
      end
      ON: begin
        if (!t_zero) begin
          timer_n = timer - 1'b1;
        end else begin
          state_n = OFF;
          timer_n = OFF_LD;
        end
      end
      OFF: begin
        if (!t_zero) begin
          timer_n = timer - 1'b1;
        end else if (pend != '0 || ev_flag) begin
          state_n = ON;
          timer_n = ON_LD;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
      led   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      led   <= (state_n == ON);
      busy  <= (state_n != IDLE);
    end
  end

  event_blinker_sat_counter #(
    .W   (PEND_W),
    .MAX (MAX_PEND)
  ) u_pend (
    .clk   (clk_d),
    .rst_n (rst_n),
    .inc   (inc),
    .dec   (dec),
    .count (pend)
  );

`ifdef EVBLINK_OVF_EN
  localparam logic [PEND_W-1:0] MAXV = PEND_W'(MAX_PEND);

  always_ff @(posedge clk_d or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (inc && pend == MAXV) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_event_blinker.sv
// Directed scoreboard bench for event_blinker (ON=4, OFF=2, MAX_PEND=3).
module tb_event_blinker;

  localparam int PW = 2;

  logic          clk_d = 1'b0;
  logic          rst_n = 1'b0;
  logic          ev_flag = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend;
`ifdef EVBLINK_OVF_EN
  logic          ovf;
`endif

  event_blinker #(
    .ON_CYC   (4),
    .OFF_CYC  (2),
    .MAX_PEND (3),
    .CNT_W    (3),
    .PEND_W   (PW)
  ) dut (
    .clk_d   (clk_d),
    .rst_n   (rst_n),
    .ev_flag (ev_flag),
    .led     (led),
    .busy    (busy),
    .pend    (pend)
`ifdef EVBLINK_OVF_EN
    ,
    .ovf     (ovf)
`endif
  );

  always #5 clk_d = ~clk_d;

  typedef struct packed {
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t  sb[$];
  int    compared = 0;
  int    mismatched = 0;
  int    blinks = 0;
  int    b0;
  logic  ovf_exp = 1'b0;
  string tag = "init";

  always @(posedge led) blinks++;

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    compared += 3;
    assert (led === e.led) else begin
      mismatched++;
      $error("FAIL %s led: got %b expected %b", tag, led, e.led);
    end
    assert (busy === e.busy) else begin
      mismatched++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, e.busy);
    end
    assert (pend === e.pend) else begin
      mismatched++;
      $error("FAIL %s pend: got %0d expected %0d", tag, pend, e.pend);
    end
`ifdef EVBLINK_OVF_EN
    compared++;
    assert (ovf === e.ovf) else begin
      mismatched++;
      $error("FAIL %s ovf: got %b expected %b", tag, ovf, e.ovf);
    end
`endif
  endtask

  task automatic step(
    input logic          ev,
    input logic          l,
    input logic          b,
    input logic [PW-1:0] p
  );
    exp_t e;
    ev_flag = ev;
    e = '{led: l, busy: b, pend: p, ovf: ovf_exp};
    sb.push_back(e);
    @(posedge clk_d);
    #1;
    ev_flag = 1'b0;
    check_out();
  endtask

  task automatic reset_check();
    exp_t e;
    ovf_exp = 1'b0;
    e = '{led: 1'b0, busy: 1'b0, pend: '0, ovf: 1'b0};
    sb.push_back(e);
    check_out();
  endtask

  task automatic check_blinks(input int n);
    compared++;
    assert (blinks - b0 === n) else begin
      mismatched++;
      $error("FAIL %s blinks: got %0d expected %0d", tag, blinks - b0, n);
    end
  endtask

  initial begin
    tag = "reset";
    #2;
    reset_check();
    @(negedge clk_d);
    rst_n = 1'b1;

    tag = "single";
    b0 = blinks;
    step(1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    check_blinks(1);

    tag = "b2b";
    b0 = blinks;
    step(1, 1, 1, 0);
    step(0, 1, 1, 0);
    step(1, 1, 1, 1);
    step(0, 1, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_blinks(2);

    tag = "sat";
    b0 = blinks;
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 2);
    step(1, 1, 1, 3);
    ovf_exp = 1'b1;
    step(1, 0, 1, 3);
    step(1, 0, 1, 3);
    step(0, 1, 1, 2);
    repeat (3) step(0, 1, 1, 2);
    repeat (2) step(0, 0, 1, 2);
    step(0, 1, 1, 1);
    repeat (3) step(0, 1, 1, 1);
    repeat (2) step(0, 0, 1, 1);
    step(0, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    repeat (2) step(0, 0, 0, 0);
    check_blinks(4);

    tag = "simul";
    step(1, 1, 1, 0);
    step(1, 1, 1, 1);
    step(1, 1, 1, 2);
    step(0, 1, 1, 2);
    repeat (2) step(0, 0, 1, 2);
    step(1, 1, 1, 2);
    step(0, 1, 1, 2);

    tag = "rst_mid";
    #2;
    rst_n = 1'b0;
    #1;
    reset_check();
    @(negedge clk_d);
    rst_n = 1'b1;
    tag = "post_rst";
    repeat (3) step(0, 0, 0, 0);

    tag = "direct";
    b0 = blinks;
    step(1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(1, 1, 1, 0);
    repeat (3) step(0, 1, 1, 0);
    repeat (2) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_blinks(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
